// File: rtl/modular_mult_radix.sv
// modular_mult_radix: iterative (A*B) mod N consuming DIGIT multiplier bits per cycle,
// reducing A in the same datapath first; valid/ready handshakes on both sides.
module modular_mult_radix #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             err
);
  localparam int C  = WIDTH / DIGIT;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("modular_mult_radix: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic [1:0] {IDLE, REDUCE, MULT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, r_q, r_d, p_q, p_d, z_q, z_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] nxt;
  logic             in_mult, last;

  // One radix step per bit: double, conditionally add, keep the value below n.
  function automatic logic [WIDTH-1:0] chain(input logic [WIDTH-1:0] x,
                                             input logic [DIGIT-1:0] bits,
                                             input logic [WIDTH-1:0] addend,
                                             input logic [WIDTH-1:0] n);
    logic [WIDTH:0] t, nn;
    nn = {1'b0, n};
    t  = {1'b0, x};
    for (int i = DIGIT - 1; i >= 0; i--) begin
      t = t << 1;
      if (t >= nn) t = t - nn;
      if (bits[i]) t = t + {1'b0, addend};
      if (t >= nn) t = t - nn;
    end
    return t[WIDTH-1:0];
  endfunction

  // REDUCE folds A into R with addend 1; MULT folds B into P with addend R.
  assign in_mult = state_q == MULT;
  assign last    = cnt_q == CW'(C - 1);
  assign nxt     = chain(in_mult ? p_q : r_q,
                         in_mult ? b_q[WIDTH-1 -: DIGIT] : a_q[WIDTH-1 -: DIGIT],
                         in_mult ? r_q : WIDTH'(1), n_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    r_d     = r_q;
    p_d     = p_q;
    z_d     = z_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d   = A;
        b_d   = B;
        n_d   = N;
        cnt_d = '0;
        r_d   = '0;
        if (N == '0) begin
          state_d = DONE;
          z_d     = '0;
          err_d   = 1'b1;
        end else begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        r_d   = nxt;
        a_d   = a_q << DIGIT;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = MULT;
          p_d     = '0;
          cnt_d   = '0;
        end
      end
      MULT: begin
        p_d   = nxt;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          z_d     = nxt;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      r_q     <= r_d;
      p_q     <= p_d;
      z_q     <= z_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign Z         = z_q;
  assign err       = err_q;
endmodule

// File: tb/tb_modular_mult_radix.sv
// tb_modular_mult_radix: directed and random checks of three WIDTH=8 instances
// (DIGIT 2, 1, 8) against an arithmetic (A*B) mod N reference.
module tb_modular_mult_radix;
  localparam int W = 8;

  logic         clk = 1'b0, reset = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] A = '0, B = '0, N = '0;
  logic         in_ready2, out_valid2, err2, in_ready1, out_valid1, err1, in_ready8, out_valid8, err8;
  logic [W-1:0] z2, z1, z8;
  int           passed = 0, total = 0;

  always #5 clk = ~clk;

  modular_mult_radix #(.WIDTH(W), .DIGIT(2)) u2 (.clk(clk), .reset(reset), .in_valid(in_valid),
    .in_ready(in_ready2), .A(A), .B(B), .N(N), .out_valid(out_valid2), .out_ready(out_ready),
    .Z(z2), .err(err2));
  modular_mult_radix #(.WIDTH(W), .DIGIT(1)) u1 (.clk(clk), .reset(reset), .in_valid(in_valid),
    .in_ready(in_ready1), .A(A), .B(B), .N(N), .out_valid(out_valid1), .out_ready(out_ready),
    .Z(z1), .err(err1));
  modular_mult_radix #(.WIDTH(W), .DIGIT(8)) u8 (.clk(clk), .reset(reset), .in_valid(in_valid),
    .in_ready(in_ready8), .A(A), .B(B), .N(N), .out_valid(out_valid8), .out_ready(out_ready),
    .Z(z8), .err(err8));

  function automatic logic [W-1:0] ref_z(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] n);
    if (n == 0) return '0;
    return W'((int'(a) * int'(b)) % int'(n));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present an operation, let it be accepted, then scramble the inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready2, 1);
    A = a; B = b; N = n; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); N = W'($urandom);
  endtask

  // Edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    if (out_valid2) lat = 0;
    else for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid2) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n);
    int lat;
    issue(a, b, n);
    wait_out(lat);
    chk("edges_to_valid", lat, (n == 0) ? 0 : 8);
    chk("Z", z2, ref_z(a, b, n));
    chk("err", err2, n == 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_handshake", in_ready2, 1);
    chk("out_valid_after_handshake", out_valid2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, lat1, lat8;
    logic [W-1:0] zs1, zs8, zhold;
    #12;
    chk("reset_in_ready", in_ready2, 1);
    chk("reset_out_valid", out_valid2, 0);
    chk("reset_Z", z2, 0);
    chk("reset_err", err2, 0);
    @(negedge clk);
    reset = 1'b0;

    // Same operation on all three digit widths, A >= N.
    issue(8'd255, 8'd255, 8'd13);
    lat = -1; lat1 = -1; lat8 = -1; zs1 = '0; zs8 = '0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (out_valid2 && lat < 0) lat = k;
      if (out_valid1 && lat1 < 0) begin lat1 = k; zs1 = z1; end
      if (out_valid8 && lat8 < 0) begin lat8 = k; zs8 = z8; end
    end
    chk("d2_latency", lat, 8);
    chk("d1_latency", lat1, 16);
    chk("d8_latency", lat8, 2);
    chk("d2_Z_255_255_13", z2, 12);
    chk("d1_Z_255_255_13", zs1, 12);
    chk("d8_Z_255_255_13", zs8, 12);

    run(8'd200, 8'd150, 8'd251);
    chk("Z_200_150_251", z2, 131);
    run(8'd7, 8'd9, 8'd0);
    run(8'd3, 8'd5, 8'd7);
    chk("Z_3_5_7", z2, 1);
    run(8'd77, 8'd91, 8'd1);
    run(8'd123, 8'd0, 8'd97);
    run(8'd254, 8'd254, 8'd255);
    chk("Z_254_254_255", z2, 1);
    run(8'd60, 8'd33, 8'd30);

    for (int i = 0; i < 12; i++)
      run(W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 255)));

    // in_valid while busy is ignored.
    issue(8'd45, 8'd67, 8'd89);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("in_ready_busy", in_ready2, 0);
      A = W'($urandom); B = W'($urandom); N = W'($urandom_range(1, 255)); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    chk("busy_edges_to_valid", lat, 4);
    chk("busy_Z", z2, ref_z(8'd45, 8'd67, 8'd89));
    @(posedge clk);
    #1;

    // Backpressure: result holds while out_ready is low.
    @(negedge clk);
    out_ready = 1'b0;
    issue(8'd199, 8'd188, 8'd177);
    wait_out(lat);
    zhold = ref_z(8'd199, 8'd188, 8'd177);
    chk("bp_edges_to_valid", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid2, 1);
      chk("bp_Z", z2, zhold);
      chk("bp_err", err2, 0);
      chk("bp_in_ready", in_ready2, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", in_ready2, 1);
    chk("bp_release_out_valid", out_valid2, 0);
    chk("Z_held_in_idle", z2, zhold);

    // Asynchronous reset while in MULT.
    issue(8'd200, 8'd150, 8'd251);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_in_ready", in_ready2, 1);
    chk("abort_out_valid", out_valid2, 0);
    chk("abort_Z", z2, 0);
    chk("abort_err", err2, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid2, 0);
    end
    reset = 1'b0;
    run(8'd200, 8'd150, 8'd251);
    chk("post_reset_Z", z2, 131);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
